// File: rtl/aes_job_scheduler.sv
// rtl/aes_job_scheduler.sv - two-requester round-robin job scheduler for an AES core
//
// Ports:
//   clk, rst                   clock, synchronous active-low reset
//   req*/action*/keylen*/block* per-requester job request and job fields
//   gnt*, done*, err*          one-hot grant, completion pulse, timeout-abort pulse
//   result                     last completed AES output, held until the next done
//   busy                       high whenever the FSM is not in IDLE
//   aes_encdec/keylen/block    registered job fields driven to the core
//   aes_init, aes_next         one-cycle core strobes
//   aes_ready, aes_result_valid, aes_result   core status and output
//
// Build option: AES_KEY_CACHE_EN remembers the keylen of the last successful
// key init so a following job with the same keylen goes straight to NEXT.

module aes_job_scheduler #(
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic         action0,
  input  logic         action1,
  input  logic         keylen0,
  input  logic         keylen1,
  input  logic [127:0] block0,
  input  logic [127:0] block1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic         err0,
  output logic         err1,
  output logic [127:0] result,
  output logic         busy,
  output logic         aes_encdec,
  output logic         aes_keylen,
  output logic [127:0] aes_block,
  output logic         aes_init,
  output logic         aes_next,
  input  logic         aes_ready,
  input  logic         aes_result_valid,
  input  logic [127:0] aes_result
);

  // Timer is at least 13 bits wide, wider if TIMEOUT needs it.
  localparam int TW = ($clog2(TIMEOUT + 1) > 13) ? $clog2(TIMEOUT + 1) : 13;
  // Aborting on the cycle the timer holds TIMEOUT-1 means the FSM spends
  // exactly TIMEOUT cycles in the wait state, and the count reaches TIMEOUT
  // as ERR is entered.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    IW1,
    IW2,
    WAIT_RDY,
    NEXT,
    NW1,
    NW2,
    WAIT_RES,
    DONE,
    ERR
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          winner;       // requester owning the current job
  logic          last_served;  // requester that finished (or aborted) most recently

  logic          any_req;
  logic          pick;
  logic          sel_action;
  logic          sel_keylen;
  logic [127:0]  sel_block;
  logic          cache_hit;
  logic          timed_out;

  // Arbitration: a sole requester always wins; on contention the requester
  // that was not served last wins.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      pick = ~last_served;
    end else begin
      pick = req1;
    end
    sel_action = pick ? action1 : action0;
    sel_keylen = pick ? keylen1 : keylen0;
    sel_block  = pick ? block1  : block0;
  end

  assign timed_out = (timer == TMO_LAST);

`ifdef AES_KEY_CACHE_EN
  logic cache_valid;
  logic cache_keylen;

  // The core keeps its expanded key between jobs, so a matching keylen lets
  // the next job skip the init sequence entirely.
  assign cache_hit = cache_valid && (cache_keylen == sel_keylen);
`else
  assign cache_hit = 1'b0;
`endif

  // Every output is registered and set on the edge that enters the state
  // it belongs to, so strobes and pulses line up with their state cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      timer       <= '0;
      winner      <= 1'b0;
      last_served <= 1'b1;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      result      <= '0;
      busy        <= 1'b0;
      aes_encdec  <= 1'b0;
      aes_keylen  <= 1'b0;
      aes_block   <= '0;
      aes_init    <= 1'b0;
      aes_next    <= 1'b0;
`ifdef AES_KEY_CACHE_EN
      cache_valid  <= 1'b0;
      cache_keylen <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Job fields are captured only here; later input changes are ignored.
          if (any_req) begin
            winner     <= pick;
            aes_encdec <= sel_action;
            aes_keylen <= sel_keylen;
            aes_block  <= sel_block;
            gnt0       <= ~pick;
            gnt1       <= pick;
            busy       <= 1'b1;
            if (cache_hit) begin
              aes_next <= 1'b1;
              state    <= NEXT;
            end else begin
              aes_init <= 1'b1;
              state    <= INIT;
            end
          end
        end

        INIT: begin
          aes_init <= 1'b0;
          state    <= IW1;
        end

        IW1: state <= IW2;

        IW2: begin
          timer <= '0;
          state <= WAIT_RDY;
        end

        WAIT_RDY: begin
          timer <= timer + 1'b1;
          if (aes_ready) begin
            aes_next <= 1'b1;
            state    <= NEXT;
`ifdef AES_KEY_CACHE_EN
            cache_valid  <= 1'b1;
            cache_keylen <= aes_keylen;
`endif
          end else if (timed_out) begin
            err0        <= ~winner;
            err1        <= winner;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            last_served <= winner;
            state       <= ERR;
`ifdef AES_KEY_CACHE_EN
            cache_valid <= 1'b0;
`endif
          end
        end

        NEXT: begin
          aes_next <= 1'b0;
          state    <= NW1;
        end

        NW1: state <= NW2;

        NW2: begin
          timer <= '0;
          state <= WAIT_RES;
        end

        WAIT_RES: begin
          timer <= timer + 1'b1;
          if (aes_result_valid) begin
            result      <= aes_result;
            done0       <= ~winner;
            done1       <= winner;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            last_served <= winner;
            state       <= DONE;
          end else if (timed_out) begin
            err0        <= ~winner;
            err1        <= winner;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            last_served <= winner;
            state       <= ERR;
`ifdef AES_KEY_CACHE_EN
            cache_valid <= 1'b0;
`endif
          end
        end

        DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        ERR: begin
          err0  <= 1'b0;
          err1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// tb/tb_aes_job_scheduler.sv - directed self-checking bench for aes_job_scheduler

module tb_aes_job_scheduler;

  localparam logic [127:0] K_BLK = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_RES = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] R2    = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] R4    = 128'hdeadbeef00000000cafef00d11112222;
  localparam logic [127:0] R5    = 128'h5a5a5a5aa5a5a5a5f0f0f0f00f0f0f0f;
  localparam logic [127:0] B1    = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] B5    = 128'h13579bdf2468ace013579bdf2468ace0;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic         action0 = 1'b0, action1 = 1'b0;
  logic         keylen0 = 1'b0, keylen1 = 1'b0;
  logic [127:0] block0 = '0, block1 = '0;
  logic         gnt0, gnt1, done0, done1, err0, err1, busy;
  logic [127:0] result;
  logic         aes_encdec, aes_keylen, aes_init, aes_next;
  logic [127:0] aes_block;
  logic         aes_ready = 1'b0, aes_result_valid = 1'b0;
  logic [127:0] aes_result;
  logic [127:0] core_res = K_RES;
  logic         mute_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int n_init = 0, n_next = 0, n_done0 = 0, n_done1 = 0, n_err0 = 0, n_err1 = 0, n_gnt1 = 0;
  int t_init = 0, t_done0 = 0, t_err0 = 0, t_gnt1 = 0;
  logic gnt1_q = 1'b0;
  int rdy_cnt = 0, res_cnt = 0;

  assign aes_result = core_res;

  aes_job_scheduler #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .action0(action0), .action1(action1),
    .keylen0(keylen0), .keylen1(keylen1),
    .block0(block0), .block1(block1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .err0(err0), .err1(err1),
    .result(result), .busy(busy),
    .aes_encdec(aes_encdec), .aes_keylen(aes_keylen), .aes_block(aes_block),
    .aes_init(aes_init), .aes_next(aes_next),
    .aes_ready(aes_ready), .aes_result_valid(aes_result_valid), .aes_result(aes_result)
  );

  always #5 clk = ~clk;

  // Core model: ready 5 cycles after an init strobe, result_valid 10 cycles
  // after a next strobe, each a one-cycle pulse.
  always @(negedge clk) begin
    aes_ready = 1'b0;
    aes_result_valid = 1'b0;
    if (rdy_cnt != 0) begin
      rdy_cnt = rdy_cnt - 1;
      if (rdy_cnt == 0 && !mute_ready) aes_ready = 1'b1;
    end
    if (res_cnt != 0) begin
      res_cnt = res_cnt - 1;
      if (res_cnt == 0) aes_result_valid = 1'b1;
    end
    if (aes_init) rdy_cnt = 5;
    if (aes_next) res_cnt = 10;
  end

  // Event monitor: counts strobes/pulses and records the cycle they occurred.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (aes_init) begin n_init = n_init + 1; t_init = cyc; end
    if (aes_next) n_next = n_next + 1;
    if (done0) begin n_done0 = n_done0 + 1; t_done0 = cyc; end
    if (done1) n_done1 = n_done1 + 1;
    if (err0) begin n_err0 = n_err0 + 1; t_err0 = cyc; end
    if (err1) n_err1 = n_err1 + 1;
    if (gnt1) n_gnt1 = n_gnt1 + 1;
    if (gnt1 && !gnt1_q) t_gnt1 = cyc;
    gnt1_q = gnt1;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%032h expected=%032h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(3);
    rst = 1'b1;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, x0, d0, g0, e0, base, exp_init_b, sum_d, sum_e;
    logic [127:0] held;

`ifdef AES_KEY_CACHE_EN
    exp_init_b = 0;
`else
    exp_init_b = 1;
`endif

    // ---- reset state
    step(3);
    check_bit("rst_gnt0", gnt0, 1'b0);
    check_bit("rst_gnt1", gnt1, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done0", done0, 1'b0);
    check_bit("rst_err0", err0, 1'b0);
    check_bit("rst_init", aes_init, 1'b0);
    check_bit("rst_next", aes_next, 1'b0);
    check_vec("rst_result", result, '0);
    check_vec("rst_block", aes_block, '0);
    check_bit("rst_encdec", aes_encdec, 1'b0);
    check_bit("rst_keylen", aes_keylen, 1'b0);
    rst = 1'b1;
    step(1);

    // ---- single encrypt job from requester 0
    i0 = n_init; x0 = n_next; d0 = n_done0; g0 = n_gnt1;
    req0 = 1'b1; action0 = 1'b1; keylen0 = 1'b0; block0 = K_BLK;
    step(1);
    check_bit("j1_gnt0", gnt0, 1'b1);
    check_bit("j1_init", aes_init, 1'b1);
    check_bit("j1_busy", busy, 1'b1);
    check_bit("j1_encdec", aes_encdec, 1'b1);
    check_bit("j1_keylen", aes_keylen, 1'b0);
    check_vec("j1_block", aes_block, K_BLK);
    for (int k = 0; k < 200 && n_done0 == d0; k++) step(1);
    req0 = 1'b0;
    check_int("j1_done_seen", n_done0 - d0, 1);
    check_int("j1_latency", t_done0 - t_init, 17);
    check_vec("j1_result", result, K_RES);
    check_bit("j1_gnt0_drop", gnt0, 1'b0);
    check_int("j1_init_cnt", n_init - i0, 1);
    check_int("j1_next_cnt", n_next - x0, 1);
    check_int("j1_gnt1_never", n_gnt1 - g0, 0);
    step(1);
    check_bit("j1_done_pulse", done0, 1'b0);
    check_bit("j1_busy_low", busy, 1'b0);

    // ---- round robin
    do_reset();
    core_res = R2;
    d0 = n_done0;
    req0 = 1'b1; req1 = 1'b1; action0 = 1'b1; action1 = 1'b0; keylen1 = 1'b0; block1 = B1;
    step(1);
    check_bit("rr_first_gnt0", gnt0, 1'b1);
    check_bit("rr_first_gnt1", gnt1, 1'b0);
    for (int k = 0; k < 200 && n_done0 == d0; k++) step(1);
    req0 = 1'b0;
    check_int("rr_done0_seen", n_done0 - d0, 1);
    base = n_done1;
    step(2);
    check_bit("rr_gnt1", gnt1, 1'b1);
    check_int("rr_gnt1_delay", t_gnt1 - t_done0, 2);
    check_bit("rr_encdec1", aes_encdec, 1'b0);
    check_vec("rr_block1", aes_block, B1);
    for (int k = 0; k < 200 && n_done1 == base; k++) step(1);
    req1 = 1'b0;
    check_int("rr_done1_seen", n_done1 - base, 1);
    check_vec("rr_result", result, R2);
    step(1);
    d0 = n_done0;
    req0 = 1'b1; req1 = 1'b1;
    step(1);
    check_bit("rr_again_gnt0", gnt0, 1'b1);
    check_bit("rr_again_gnt1", gnt1, 1'b0);
    for (int k = 0; k < 200 && n_done0 == d0; k++) step(1);
    req0 = 1'b0; req1 = 1'b0;
    check_int("rr_again_done0", n_done0 - d0, 1);
    step(2);

    // ---- timeout in WAIT_RDY
    held = result;
    mute_ready = 1'b1;
    d0 = n_done0; e0 = n_err0;
    req0 = 1'b1; keylen0 = 1'b1;
    for (int k = 0; k < 200 && n_err0 == e0; k++) step(1);
    req0 = 1'b0;
    check_int("tmo_err_seen", n_err0 - e0, 1);
    check_int("tmo_err_delay", t_err0 - t_init, 19);
    check_int("tmo_no_done", n_done0 - d0, 0);
    check_vec("tmo_result_held", result, held);
    check_bit("tmo_gnt0_drop", gnt0, 1'b0);
    step(1);
    check_bit("tmo_busy_low", busy, 1'b0);
    check_bit("tmo_err_pulse", err0, 1'b0);
    mute_ready = 1'b0;
    step(2);

    // ---- back-to-back keylen=1 jobs
    core_res = R4;
    d0 = n_done0;
    req0 = 1'b1; keylen0 = 1'b1; action0 = 1'b0;
    for (int k = 0; k < 200 && n_done0 == d0; k++) step(1);
    check_int("b2b_a_done", n_done0 - d0, 1);
    i0 = n_init; x0 = n_next; d0 = n_done0;
    for (int k = 0; k < 200 && n_done0 == d0; k++) step(1);
    req0 = 1'b0;
    check_int("b2b_b_done", n_done0 - d0, 1);
    check_int("b2b_b_init", n_init - i0, exp_init_b);
    check_int("b2b_b_next", n_next - x0, 1);
    check_vec("b2b_result", result, R4);
    step(2);

    // ---- reset during WAIT_RES
    x0 = n_next;
    req0 = 1'b1; keylen0 = 1'b0;
    for (int k = 0; k < 200 && n_next == x0; k++) step(1);
    check_int("mid_next_seen", n_next - x0, 1);
    step(4);
    check_bit("mid_busy", busy, 1'b1);
    sum_d = n_done0 + n_done1;
    sum_e = n_err0 + n_err1;
    rst = 1'b0; req0 = 1'b0;
    step(2);
    rst = 1'b1;
    step(15);
    check_int("mid_no_done", n_done0 + n_done1 - sum_d, 0);
    check_int("mid_no_err", n_err0 + n_err1 - sum_e, 0);
    check_bit("mid_gnt0", gnt0, 1'b0);
    check_bit("mid_busy_low", busy, 1'b0);
    check_vec("mid_result", result, '0);
    check_vec("mid_block", aes_block, '0);
    check_bit("mid_encdec", aes_encdec, 1'b0);
    check_bit("mid_keylen", aes_keylen, 1'b0);
    check_bit("mid_next_low", aes_next, 1'b0);

    core_res = R5;
    i0 = n_init; base = n_done1;
    req1 = 1'b1; action1 = 1'b1; keylen1 = 1'b1; block1 = B5;
    for (int k = 0; k < 200 && n_done1 == base; k++) step(1);
    req1 = 1'b0;
    check_int("post_done1", n_done1 - base, 1);
    check_int("post_init", n_init - i0, 1);
    check_vec("post_result", result, R5);
    check_vec("post_block", aes_block, B5);
    check_bit("post_keylen", aes_keylen, 1'b1);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
